scramble_sequencer: RTL and testbench

SCRAMBLE_SEQUENCER -- requirements
Module: scramble_sequencer

---
 rtl/scramble_sequencer_pkg.sv | 21 ++
 rtl/scramble_sequencer_lfsr16.sv | 33 +++
 rtl/scramble_sequencer.sv | 168 ++++++++++++++++
 tb/tb_scramble_sequencer.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/scramble_sequencer_pkg.sv
// rtl/scramble_sequencer_pkg.sv - shared constants, FSM encoding and LFSR step for the scramble sequencer
package scramble_sequencer_pkg;

  localparam int MAX_IMAGE_SIZE = 16;
  localparam int POS_W = $clog2(MAX_IMAGE_SIZE);
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_ISSUE = 3'd2,
    ST_GAP   = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Galois right-shift step; taps fold in only when a one falls off the end
  function automatic logic [15:0] lfsr_step(input logic [15:0] cur);
    lfsr_step = cur[0] ? ((cur >> 1) ^ LFSR_TAPS) : (cur >> 1);
  endfunction

endpackage

// File: rtl/scramble_sequencer_lfsr16.sv
// rtl/scramble_sequencer_lfsr16.sv - 16-bit Galois LFSR that steps only when asked
module lfsr16
  import scramble_sequencer_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        sysclk,
  input  logic        rst_n,
  input  logic        advance,
  output logic [15:0] value
);

  logic [15:0] value_q;
  logic [15:0] value_d;

  always_comb begin
    value_d = value_q;
    if (advance) begin
      value_d = lfsr_step(value_q);
    end
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      value_q <= SEED;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;

endmodule

// File: rtl/scramble_sequencer.sv
// rtl/scramble_sequencer.sv - issues a burst of pseudo-random offset moves, otherwise forwards user moves
module scramble_sequencer
  import scramble_sequencer_pkg::*;
#(
  parameter int          SCRAMBLE_MOVES = 64,
  parameter int          GAP_CYCLES     = 4,
  parameter int          CLEAR_CYCLES   = 2,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
  input  logic             sysclk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             user_write,
  input  logic [POS_W-1:0] user_pos,
  input  logic             user_horizontal,
  input  logic             user_increase,
  output logic             ram_write,
  output logic [POS_W-1:0] ram_write_pos,
  output logic             ram_write_horizontal,
  output logic             ram_write_increase,
  output logic             ram_reset,
  output logic             busy,
  output logic             scramble,
  output logic             user_dropped
);

  localparam logic [7:0] MOVES_TOTAL = 8'(SCRAMBLE_MOVES);
  localparam logic [3:0] CLR_LAST    = 4'(CLEAR_CYCLES - 1);
  localparam logic [3:0] GAP_LAST    = 4'(GAP_CYCLES - 1);

  state_t           state_q, state_d;
  logic [7:0]       move_cnt_q, move_cnt_d;
  logic [3:0]       phase_q, phase_d;
  logic             ram_write_q, ram_write_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic             horiz_q, horiz_d;
  logic             incr_q, incr_d;
  logic             ram_reset_q, ram_reset_d;
  logic             busy_q, busy_d;
  logic             scramble_q, scramble_d;
  logic             dropped_q, dropped_d;

  logic             lfsr_advance;
  logic [15:0]      lfsr_value;
  logic [15:0]      lfsr_issue;

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .sysclk  (sysclk),
    .rst_n   (rst_n),
    .advance (lfsr_advance),
    .value   (lfsr_value)
  );

  // Back-to-back issues (no gap) must see the value the LFSR steps to on this edge
  assign lfsr_issue = lfsr_advance ? lfsr_step(lfsr_value) : lfsr_value;

  always_comb begin
    state_d      = state_q;
    move_cnt_d   = move_cnt_q;
    phase_d      = phase_q;
    ram_write_d  = 1'b0;
    pos_d        = pos_q;
    horiz_d      = horiz_q;
    incr_d       = incr_q;
    scramble_d   = scramble_q;
    lfsr_advance = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_CLEAR;
          move_cnt_d = 8'd0;
          phase_d    = 4'd0;
          scramble_d = 1'b0;
        end else if (user_write) begin
          ram_write_d = 1'b1;
          pos_d       = user_pos;
          horiz_d     = user_horizontal;
          incr_d      = user_increase;
        end
      end
      ST_CLEAR: begin
        if (phase_q == CLR_LAST) begin
          state_d = ST_ISSUE;
        end else begin
          phase_d = phase_q + 4'd1;
        end
      end
      ST_ISSUE: begin
        lfsr_advance = 1'b1;
        move_cnt_d   = move_cnt_q + 8'd1;
        phase_d      = 4'd0;
        if (move_cnt_d == MOVES_TOTAL) begin
          state_d = ST_DONE;
        end else if (GAP_CYCLES == 0) begin
          state_d = ST_ISSUE;
        end else begin
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        if (phase_q == GAP_LAST) begin
          state_d = ST_ISSUE;
        end else begin
          phase_d = phase_q + 4'd1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs are registered against the next state so they line up with it
    if (state_d == ST_ISSUE) begin
      ram_write_d = 1'b1;
      pos_d       = lfsr_issue[POS_W-1:0];
      horiz_d     = lfsr_issue[4];
      incr_d      = lfsr_issue[5];
    end
    if (state_d == ST_DONE) begin
      scramble_d = 1'b1;
    end
    ram_reset_d = (state_d == ST_CLEAR);
    busy_d      = (state_d != ST_IDLE);
    dropped_d   = user_write && ((state_q != ST_IDLE) || start);
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      move_cnt_q  <= 8'd0;
      phase_q     <= 4'd0;
      ram_write_q <= 1'b0;
      pos_q       <= '0;
      horiz_q     <= 1'b0;
      incr_q      <= 1'b0;
      ram_reset_q <= 1'b0;
      busy_q      <= 1'b0;
      scramble_q  <= 1'b0;
      dropped_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      move_cnt_q  <= move_cnt_d;
      phase_q     <= phase_d;
      ram_write_q <= ram_write_d;
      pos_q       <= pos_d;
      horiz_q     <= horiz_d;
      incr_q      <= incr_d;
      ram_reset_q <= ram_reset_d;
      busy_q      <= busy_d;
      scramble_q  <= scramble_d;
      dropped_q   <= dropped_d;
    end
  end

  assign ram_write            = ram_write_q;
  assign ram_write_pos        = pos_q;
  assign ram_write_horizontal = horiz_q;
  assign ram_write_increase   = incr_q;
  assign ram_reset            = ram_reset_q;
  assign busy                 = busy_q;
  assign scramble             = scramble_q;
  assign user_dropped         = dropped_q;

endmodule

// File: tb/tb_scramble_sequencer.sv
// tb/tb_scramble_sequencer.sv - randomized and directed bench for scramble_sequencer against a timeline model
module tb_scramble_sequencer;

  localparam int M = 64;
  localparam int G = 4;
  localparam int C = 2;
  localparam logic [15:0] SEED = 16'hACE1;
  localparam int D = C + 1 + (M - 1) * (G + 1) + 1;

  logic       sysclk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       user_write = 1'b0;
  logic [3:0] user_pos = 4'd0;
  logic       user_horizontal = 1'b0;
  logic       user_increase = 1'b0;
  logic       ram_write, ram_write_horizontal, ram_write_increase;
  logic [3:0] ram_write_pos;
  logic       ram_reset, busy, scramble, user_dropped;

  logic       start2 = 1'b0;
  logic       uw2 = 1'b0;
  logic [3:0] upos2 = 4'd0;
  logic       uh2 = 1'b0;
  logic       ui2 = 1'b0;
  logic       d2_wr, d2_h, d2_i, d2_rst, d2_busy, d2_scr, d2_drop;
  logic [3:0] d2_pos;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 sysclk = ~sysclk;

  scramble_sequencer dut (
    .sysclk(sysclk), .rst_n(rst_n), .start(start), .user_write(user_write),
    .user_pos(user_pos), .user_horizontal(user_horizontal), .user_increase(user_increase),
    .ram_write(ram_write), .ram_write_pos(ram_write_pos),
    .ram_write_horizontal(ram_write_horizontal), .ram_write_increase(ram_write_increase),
    .ram_reset(ram_reset), .busy(busy), .scramble(scramble), .user_dropped(user_dropped)
  );

  scramble_sequencer #(.SCRAMBLE_MOVES(1), .GAP_CYCLES(0)) dut2 (
    .sysclk(sysclk), .rst_n(rst_n), .start(start2), .user_write(uw2),
    .user_pos(upos2), .user_horizontal(uh2), .user_increase(ui2),
    .ram_write(d2_wr), .ram_write_pos(d2_pos),
    .ram_write_horizontal(d2_h), .ram_write_increase(d2_i),
    .ram_reset(d2_rst), .busy(d2_busy), .scramble(d2_scr), .user_dropped(d2_drop)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Timeline model: a scramble is a fixed schedule measured from the edge that accepts start
  logic       s_valid = 1'b0, s_start = 1'b0, s_uw = 1'b0, s_h = 1'b0, s_i = 1'b0;
  logic [3:0] s_pos = 4'd0;
  bit         in_scr;
  int         rel;
  logic [15:0] m_lfsr;
  logic       e_wr, e_h, e_i, e_rst, e_busy, e_scr, e_drop;
  logic [3:0] e_pos;

  function automatic bit is_write_slot(input int r);
    int k;
    if (r < C + 1) return 1'b0;
    if ((r - (C + 1)) % (G + 1) != 0) return 1'b0;
    k = (r - (C + 1)) / (G + 1);
    return (k < M);
  endfunction

  always @(posedge sysclk) begin
    s_valid <= rst_n;
    s_start <= start;
    s_uw    <= user_write;
    s_pos   <= user_pos;
    s_h     <= user_horizontal;
    s_i     <= user_increase;
  end

  task automatic model_reset();
    in_scr = 1'b0; rel = 0; m_lfsr = SEED;
    e_wr = 0; e_pos = 0; e_h = 0; e_i = 0; e_rst = 0; e_busy = 0; e_scr = 0; e_drop = 0;
  endtask

  task automatic check_outputs();
    check_eq("ram_write", 32'(ram_write), 32'(e_wr));
    check_eq("ram_write_pos", 32'(ram_write_pos), 32'(e_pos));
    check_eq("ram_write_horizontal", 32'(ram_write_horizontal), 32'(e_h));
    check_eq("ram_write_increase", 32'(ram_write_increase), 32'(e_i));
    check_eq("ram_reset", 32'(ram_reset), 32'(e_rst));
    check_eq("busy", 32'(busy), 32'(e_busy));
    check_eq("scramble", 32'(scramble), 32'(e_scr));
    check_eq("user_dropped", 32'(user_dropped), 32'(e_drop));
    check_eq("write_reset_exclusive", 32'(ram_write & ram_reset), 32'd0);
  endtask

  always @(negedge sysclk) begin
    bit was_idle;
    if (!rst_n) begin
      model_reset();
      check_outputs();
    end else if (s_valid) begin
      was_idle = !in_scr;
      e_wr = 1'b0;
      e_drop = 1'b0;
      if (in_scr) begin
        rel++;
        if (rel > D) in_scr = 1'b0;
      end
      if (was_idle && s_start) begin
        in_scr = 1'b1; rel = 1; e_scr = 1'b0;
        if (s_uw) e_drop = 1'b1;
      end else if (was_idle && s_uw) begin
        e_wr = 1'b1; e_pos = s_pos; e_h = s_h; e_i = s_i;
      end else if (!was_idle && s_uw) begin
        e_drop = 1'b1;
      end
      if (in_scr && is_write_slot(rel)) begin
        e_wr = 1'b1; e_pos = m_lfsr[3:0]; e_h = m_lfsr[4]; e_i = m_lfsr[5];
        m_lfsr = m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
      end
      if (in_scr && rel == D) e_scr = 1'b1;
      e_rst = in_scr && (rel <= C);
      e_busy = in_scr;
      check_outputs();
    end
  end

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 2000) begin
      tick();
      n++;
    end
    check_eq(tag, 32'(busy), 32'd0);
  endtask

  task automatic first_writes(input string tag);
    int gap = 0;
    start = 1'b1; tick(); start = 1'b0;
    check_eq({tag, "_rst1"}, 32'(ram_reset), 32'd1);
    tick();
    check_eq({tag, "_rst2"}, 32'(ram_reset), 32'd1);
    tick();
    check_eq({tag, "_wr1"}, 32'(ram_write), 32'd1);
    check_eq({tag, "_rst3"}, 32'(ram_reset), 32'd0);
    check_eq({tag, "_pos1"}, 32'(ram_write_pos), 32'd1);
    check_eq({tag, "_h1"}, 32'(ram_write_horizontal), 32'd0);
    check_eq({tag, "_i1"}, 32'(ram_write_increase), 32'd1);
    do begin
      tick();
      gap++;
    end while (!ram_write && gap < 20);
    check_eq({tag, "_gap"}, 32'(gap), 32'd5);
    check_eq({tag, "_pos2"}, 32'(ram_write_pos), 32'd0);
    check_eq({tag, "_h2"}, 32'(ram_write_horizontal), 32'd1);
    check_eq({tag, "_i2"}, 32'(ram_write_increase), 32'd1);
  endtask

  initial begin
    int n_wr;
    int wr_rel, scr_rel, off_rel;
    model_reset();
    repeat (3) tick();
    check_eq("reset_busy", 32'(busy), 32'd0);
    check_eq("reset_scramble", 32'(scramble), 32'd0);
    rst_n = 1'b1;
    tick();

    // Full default scramble with write count
    first_writes("scr1");
    n_wr = 2;
    while (busy && n_wr < 1000) begin
      tick();
      if (ram_write) n_wr++;
    end
    check_eq("scr1_writes", 32'(n_wr), 32'd64);
    check_eq("scr1_scramble", 32'(scramble), 32'd1);
    check_eq("scr1_busy", 32'(busy), 32'd0);

    // User move in idle
    user_write = 1'b1; user_pos = 4'd7; user_horizontal = 1'b1; user_increase = 1'b0;
    tick();
    user_write = 1'b0;
    check_eq("user_wr", 32'(ram_write), 32'd1);
    check_eq("user_pos", 32'(ram_write_pos), 32'd7);
    check_eq("user_h", 32'(ram_write_horizontal), 32'd1);
    check_eq("user_i", 32'(ram_write_increase), 32'd0);
    check_eq("user_drop", 32'(user_dropped), 32'd0);
    tick();

    // User move coincident with start, then one during a gap
    start = 1'b1; user_write = 1'b1; user_pos = 4'd3;
    tick();
    start = 1'b0; user_write = 1'b0;
    check_eq("coinc_drop", 32'(user_dropped), 32'd1);
    check_eq("coinc_wr", 32'(ram_write), 32'd0);
    repeat (3) tick();
    user_write = 1'b1; user_pos = 4'd9;
    tick();
    user_write = 1'b0;
    check_eq("gap_drop", 32'(user_dropped), 32'd1);
    check_eq("gap_wr", 32'(ram_write), 32'd0);
    wait_idle("scr2_idle");
    check_eq("scr2_scramble", 32'(scramble), 32'd1);

    // Start held across DONE restarts immediately
    start = 1'b1;
    begin
      int n = 0;
      while (!busy && n < 10) begin tick(); n++; end
      n = 0;
      while (busy && n < 2000) begin tick(); n++; end
    end
    tick();
    start = 1'b0;
    check_eq("held_restart", 32'(busy), 32'd1);
    wait_idle("scr3_idle");

    // Reset during the 10th issue, then a fresh scramble matches the seeded sequence
    start = 1'b1; tick(); start = 1'b0;
    n_wr = 0;
    begin
      int n = 0;
      while (n_wr < 10 && n < 1000) begin
        tick();
        n++;
        if (ram_write) n_wr++;
      end
    end
    check_eq("tenth_issue", 32'(n_wr), 32'd10);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_wr", 32'(ram_write), 32'd0);
    check_eq("arst_pos", 32'(ram_write_pos), 32'd0);
    check_eq("arst_h", 32'(ram_write_horizontal), 32'd0);
    check_eq("arst_i", 32'(ram_write_increase), 32'd0);
    check_eq("arst_busy", 32'(busy), 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    first_writes("post_rst");
    wait_idle("post_rst_idle");

    // Random traffic
    for (int c = 0; c < 2500; c++) begin
      start = ($urandom_range(0, 59) == 0);
      user_write = ($urandom_range(0, 3) == 0);
      user_pos = 4'($urandom_range(0, 15));
      user_horizontal = 1'($urandom_range(0, 1));
      user_increase = 1'($urandom_range(0, 1));
      tick();
    end
    start = 1'b0; user_write = 1'b0;
    wait_idle("rand_idle");

    // Single-move, no-gap instance
    start2 = 1'b1; tick(); start2 = 1'b0;
    n_wr = 0; wr_rel = 0; scr_rel = 0; off_rel = 0;
    for (int r = 1; r <= 8; r++) begin
      if (r > 1) tick();
      if (d2_wr) begin n_wr++; wr_rel = r; end
      if (d2_scr && scr_rel == 0) scr_rel = r;
      if (!d2_busy && off_rel == 0) off_rel = r;
    end
    check_eq("one_writes", 32'(n_wr), 32'd1);
    check_eq("one_wr_cycle", 32'(wr_rel), 32'd3);
    check_eq("one_done_cycle", 32'(scr_rel), 32'd4);
    check_eq("one_idle_cycle", 32'(off_rel), 32'd5);
    check_eq("one_pos", 32'(d2_pos), 32'd1);
    check_eq("one_scramble", 32'(d2_scr), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
